// File: rtl/lane_traffic_engine.sv
// -----------------------------------------------------------------------------
// lane_traffic_engine
//
// Multi-lane traffic generator for the Frogger playfield. Each lane holds a
// base position of a train of evenly spaced, wrapping cars. The lane advances
// STEP_PX pixels every (div+1) frame-start pulses, moving either right or left.
// The per-pixel query from the VGA scan reports whether the current pixel lies
// on an enabled car. The result is registered, so it appears one cycle after
// the query. Frog/car overlap seen during a frame is reported as a one-cycle
// pulse on the next frame start.
//
// Ports
//   i_Clk          pixel clock; all state changes on its rising edge
//   i_Rst_n        synchronous active-low reset
//   i_Frame_Start  1-cycle pulse at scan position (0,0)
//   i_Restart      reloads lane positions, frame counters and the hit flag
//   i_Lane_En      per-lane enable; a disabled lane is not drawn, cannot
//                  collide and keeps its position
//   i_Dir          per-lane direction: 0 = +x (right), 1 = -x (left)
//   i_Speed_Div    per-lane divisor, lane l in [l*DIV_W +: DIV_W]
//   i_H, i_V       current scan coordinates
//   i_Frog_X/Y     frog top-left corner; the frog is GRID x GRID pixels
//   o_Car_Pixel    registered: scan pixel lies on an enabled car
//   o_Lane_Id      registered: lane of that car, 0 when there is no car
//   o_Collision    1-cycle pulse: the previous frame had frog/car overlap
//   o_Lane_Pos     current base positions, lane l in [l*X_W +: X_W]
// -----------------------------------------------------------------------------
module lane_traffic_engine #(
    parameter int NUM_LANES    = 4,
    parameter int H_DISPLAY    = 640,
    parameter int V_DISPLAY    = 480,
    parameter int GRID         = 32,
    parameter int FIRST_ROW    = 8,
    parameter int CAR_W        = 32,
    parameter int CAR_SPACING  = 128,
    parameter int STEP_PX      = 2,
    parameter int INIT_STAGGER = 48,
    parameter int DIV_W        = 6,
    parameter int X_W          = 10,
    parameter int Y_W          = 10,
    localparam int LID_W       = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1
) (
    input  logic                       i_Clk,
    input  logic                       i_Rst_n,
    input  logic                       i_Frame_Start,
    input  logic                       i_Restart,
    input  logic [NUM_LANES-1:0]       i_Lane_En,
    input  logic [NUM_LANES-1:0]       i_Dir,
    input  logic [NUM_LANES*DIV_W-1:0] i_Speed_Div,
    input  logic [X_W-1:0]             i_H,
    input  logic [Y_W-1:0]             i_V,
    input  logic [X_W-1:0]             i_Frog_X,
    input  logic [Y_W-1:0]             i_Frog_Y,
    output logic                       o_Car_Pixel,
    output logic [LID_W-1:0]           o_Lane_Id,
    output logic                       o_Collision,
    output logic [NUM_LANES*X_W-1:0]   o_Lane_Pos
);

    // One extra bit on coordinate arithmetic so pos+STEP and pos+H_DISPLAY
    // never overflow before the wrap correction.
    localparam int XE_W    = X_W + 1;
    localparam int YE_W    = Y_W + 1;
    localparam int GRID_SH = $clog2(GRID);
    localparam int ROW_W   = Y_W - GRID_SH;

    localparam logic [XE_W-1:0] H_EXT      = XE_W'(H_DISPLAY);
    localparam logic [XE_W-1:0] STEP_EXT   = XE_W'(STEP_PX);
    localparam logic [XE_W-1:0] GRID_XE    = XE_W'(GRID);
    localparam logic [YE_W-1:0] GRID_YE    = YE_W'(GRID);
    localparam logic [XE_W-1:0] SP_MASK    = XE_W'(CAR_SPACING - 1);
    localparam logic [XE_W-1:0] CAR_W_XE   = XE_W'(CAR_W);
    localparam logic [Y_W-1:0]  V_LIM      = Y_W'(V_DISPLAY);

    logic [ROW_W-1:0]     scan_row;
    logic [XE_W-1:0]      h_ext;
    logic [YE_W-1:0]      v_ext;
    logic                 scan_visible;
    logic                 in_frog;
    logic [NUM_LANES-1:0] lane_hit;
    logic                 car_hit;
    logic [LID_W-1:0]     hit_lane;

    logic                 car_pixel_reg;
    logic [LID_W-1:0]     lane_id_reg;
    logic                 collision_reg;
    logic                 hit_flag_reg;

    assign scan_row     = i_V[Y_W-1:GRID_SH];
    assign h_ext        = {1'b0, i_H};
    assign v_ext        = {1'b0, i_V};
    assign scan_visible = (h_ext < H_EXT) && (i_V < V_LIM);
    assign in_frog      = (h_ext >= {1'b0, i_Frog_X}) &&
                          (h_ext <  ({1'b0, i_Frog_X} + GRID_XE)) &&
                          (v_ext >= {1'b0, i_Frog_Y}) &&
                          (v_ext <  ({1'b0, i_Frog_Y} + GRID_YE));

    genvar gi;
    generate
        for (gi = 0; gi < NUM_LANES; gi++) begin : g_lane
            localparam logic [X_W-1:0]   INIT_POS = X_W'((gi * INIT_STAGGER) % H_DISPLAY);
            localparam logic [ROW_W-1:0] LANE_ROW = ROW_W'(FIRST_ROW + gi);

            logic [X_W-1:0]   pos_reg;
            logic [DIV_W-1:0] cnt_reg;
            logic [DIV_W-1:0] div;
            logic [XE_W-1:0]  pos_ext;
            logic [XE_W-1:0]  step_next;
            logic [XE_W-1:0]  off;

            assign div     = i_Speed_Div[gi*DIV_W +: DIV_W];
            assign pos_ext = {1'b0, pos_reg};

            always_comb begin
                // Next position after one step, wrapped into [0, H_DISPLAY).
                if (i_Dir[gi]) begin
                    if (pos_ext < STEP_EXT) begin
                        step_next = pos_ext + H_EXT - STEP_EXT;
                    end else begin
                        step_next = pos_ext - STEP_EXT;
                    end
                end else begin
                    step_next = pos_ext + STEP_EXT;
                    if (step_next >= H_EXT) begin
                        step_next = step_next - H_EXT;
                    end
                end

                // Scan offset from the lane base, modulo the screen width.
                // Cars repeat every CAR_SPACING (which divides H_DISPLAY), so
                // the low bits of the offset give the position inside a car
                // pitch, and cars crossing the right edge reappear on the left.
                off = h_ext - pos_ext;
                if (h_ext < pos_ext) begin
                    off = off + H_EXT;
                end
            end

            always_ff @(posedge i_Clk) begin
                if (!i_Rst_n || i_Restart) begin
                    pos_reg <= INIT_POS;
                    cnt_reg <= '0;
                end else if (i_Frame_Start && i_Lane_En[gi]) begin
                    // A divisor lowered below the running count is not
                    // special-cased: the counter wraps through 2^DIV_W.
                    if (cnt_reg == div) begin
                        cnt_reg <= '0;
                        pos_reg <= X_W'(step_next);
                    end else begin
                        cnt_reg <= cnt_reg + DIV_W'(1);
                    end
                end
            end

            assign lane_hit[gi] = i_Lane_En[gi] && (scan_row == LANE_ROW) &&
                                  scan_visible && ((off & SP_MASK) < CAR_W_XE);
            assign o_Lane_Pos[gi*X_W +: X_W] = pos_reg;
        end
    endgenerate

    // At most one lane matches a given scan row, so a plain encoder suffices.
    always_comb begin
        hit_lane = '0;
        for (int l = 0; l < NUM_LANES; l++) begin
            if (lane_hit[l]) begin
                hit_lane = LID_W'(l);
            end
        end
    end

    assign car_hit = |lane_hit;

    always_ff @(posedge i_Clk) begin
        if (!i_Rst_n) begin
            car_pixel_reg <= 1'b0;
            lane_id_reg   <= '0;
            collision_reg <= 1'b0;
            hit_flag_reg  <= 1'b0;
        end else begin
            car_pixel_reg <= car_hit;
            lane_id_reg   <= hit_lane;
            if (i_Restart) begin
                hit_flag_reg  <= 1'b0;
                collision_reg <= 1'b0;
            end else if (i_Frame_Start) begin
                // Report the finished frame; an overlap on this very cycle
                // belongs to the frame that is starting.
                collision_reg <= hit_flag_reg;
                hit_flag_reg  <= car_hit && in_frog;
            end else begin
                collision_reg <= 1'b0;
                if (car_hit && in_frog) begin
                    hit_flag_reg <= 1'b1;
                end
            end
        end
    end

    assign o_Car_Pixel = car_pixel_reg;
    assign o_Lane_Id   = lane_id_reg;
    assign o_Collision = collision_reg;

endmodule

// File: tb/tb_lane_traffic_engine.sv
// -----------------------------------------------------------------------------
// tb_lane_traffic_engine
//
// Bench for lane_traffic_engine with default parameters. Every driven cycle
// pushes its expected {pixel, lane, collision} into a scoreboard queue; the
// entry is popped and compared on the falling edge after the DUT registers
// it. Expected values come from a fixed vector table (hand-derived) or from a
// small behavioural model of lane motion, car placement and frame collision.
// Hand-written sequences cover wrap, collision edges and restart priority.
// -----------------------------------------------------------------------------
module tb_lane_traffic_engine;

    localparam int NL        = 4;
    localparam int HD        = 640;
    localparam int VD        = 480;
    localparam int GRID      = 32;
    localparam int FIRST_ROW = 8;
    localparam int CAR_W     = 32;
    localparam int SPACING   = 128;
    localparam int STEP      = 2;
    localparam int STAGGER   = 48;
    localparam int DIV_W     = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic              rst_n;
    logic              frame_start;
    logic              restart;
    logic [NL-1:0]     lane_en;
    logic [NL-1:0]     dir;
    logic [NL*DIV_W-1:0] speed_div;
    logic [9:0]        h, v, frog_x, frog_y;
    logic              car_pixel;
    logic [1:0]        lane_id;
    logic              collision;
    logic [NL*10-1:0]  lane_pos;

    lane_traffic_engine dut (
        .i_Clk         (clk),
        .i_Rst_n       (rst_n),
        .i_Frame_Start (frame_start),
        .i_Restart     (restart),
        .i_Lane_En     (lane_en),
        .i_Dir         (dir),
        .i_Speed_Div   (speed_div),
        .i_H           (h),
        .i_V           (v),
        .i_Frog_X      (frog_x),
        .i_Frog_Y      (frog_y),
        .o_Car_Pixel   (car_pixel),
        .o_Lane_Id     (lane_id),
        .o_Collision   (collision),
        .o_Lane_Pos    (lane_pos)
    );

    typedef struct {
        int due;
        bit pix;
        int lid;
        bit col;
    } sb_t;

    typedef struct {
        int       h;
        int       v;
        bit [3:0] en;
        bit       pix;
        int       lid;
    } vec_t;

    sb_t  sbq[$];
    vec_t vt[19];

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    int mpos[NL];
    int mcnt[NL];
    bit mflag;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s got=%0d want=%0d", name, act, want);
        end
    endtask

    // Scoreboard consumer: outputs for a cycle's inputs are registered on
    // the next rising edge and compared on the falling edge after it.
    always @(negedge clk) begin
        while (sbq.size() > 0 && sbq[0].due == cyc) begin
            sb_t e;
            e = sbq.pop_front();
            check($sformatf("pix@%0d", cyc), 32'(car_pixel), 32'(e.pix));
            check($sformatf("lid@%0d", cyc), 32'(lane_id),   e.lid);
            check($sformatf("col@%0d", cyc), 32'(collision), 32'(e.col));
        end
    end

    // ---------------- behavioural model ----------------
    function automatic int model_pix(int hh, int vv);
        int row, l, start;
        if (hh >= HD || vv >= VD) return -1;
        row = vv / GRID;
        if (row < FIRST_ROW || row >= FIRST_ROW + NL) return -1;
        l = row - FIRST_ROW;
        if (!lane_en[l]) return -1;
        for (int k = 0; k < HD / SPACING; k++) begin
            start = (mpos[l] + k * SPACING) % HD;
            if (((hh - start + HD) % HD) < CAR_W) return l;
        end
        return -1;
    endfunction

    task automatic model_restart();
        for (int l = 0; l < NL; l++) begin
            mpos[l] = (l * STAGGER) % HD;
            mcnt[l] = 0;
        end
    endtask

    task automatic model_frame();
        for (int l = 0; l < NL; l++) begin
            if (lane_en[l]) begin
                if (mcnt[l] == int'(speed_div[l*DIV_W +: DIV_W])) begin
                    mcnt[l] = 0;
                    mpos[l] = dir[l] ? (mpos[l] - STEP + HD) % HD : (mpos[l] + STEP) % HD;
                end else begin
                    mcnt[l] = (mcnt[l] + 1) % 64;
                end
            end
        end
    endtask

    // Drive one cycle (called at posedge+1), push its expectation, advance
    // the model, and return at the next posedge+1 with outputs visible.
    task automatic drive_cycle(input bit fs, input bit rs, input int hh, input int vv,
                               input bit ovr, input bit opix, input int olid);
        sb_t e;
        int  lid;
        bit  ov;
        frame_start = fs;
        restart     = rs;
        h           = 10'(hh);
        v           = 10'(vv);
        lid = model_pix(hh, vv);
        ov  = (lid >= 0) && hh >= int'(frog_x) && hh < int'(frog_x) + GRID &&
              vv >= int'(frog_y) && vv < int'(frog_y) + GRID;
        e.due = cyc + 1;
        e.pix = ovr ? opix : (lid >= 0);
        e.lid = ovr ? olid : ((lid >= 0) ? lid : 0);
        e.col = (fs && !rs) ? mflag : 1'b0;
        sbq.push_back(e);
        if (rs) begin
            mflag = 1'b0;
            model_restart();
        end else if (fs) begin
            mflag = ov;
            model_frame();
        end else if (ov) begin
            mflag = 1'b1;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        drive_cycle(1'b0, 1'b0, 0, 0, 1'b0, 1'b0, 0);
    endtask

    task automatic pulse();
        drive_cycle(1'b1, 1'b0, 0, 0, 1'b0, 1'b0, 0);
        $display("frame cyc=%0d pos=%0d,%0d,%0d,%0d col=%0d", cyc,
                 lane_pos[0+:10], lane_pos[10+:10], lane_pos[20+:10], lane_pos[30+:10], collision);
    endtask

    task automatic do_restart();
        drive_cycle(1'b0, 1'b1, 0, 0, 1'b0, 1'b0, 0);
        $display("restart cyc=%0d", cyc);
    endtask

    task automatic scan_box(input int x0, input int y0, input int w, input int ht);
        for (int yy = y0; yy < y0 + ht; yy++)
            for (int xx = x0; xx < x0 + w; xx++)
                drive_cycle(1'b0, 1'b0, xx, yy, 1'b0, 1'b0, 0);
        $display("scan x=%0d..%0d y=%0d..%0d frog=(%0d,%0d)", x0, x0 + w - 1, y0, y0 + ht - 1, frog_x, frog_y);
    endtask

    task automatic check_pos_model(input string tag);
        for (int l = 0; l < NL; l++)
            check($sformatf("%s_pos%0d", tag, l), 32'(lane_pos[l*10 +: 10]), mpos[l]);
    endtask

    task automatic check_pos_hand(input string tag, input int p0, input int p1, input int p2, input int p3);
        check({tag, "_pos0"}, 32'(lane_pos[0  +: 10]), p0);
        check({tag, "_pos1"}, 32'(lane_pos[10 +: 10]), p1);
        check({tag, "_pos2"}, 32'(lane_pos[20 +: 10]), p2);
        check({tag, "_pos3"}, 32'(lane_pos[30 +: 10]), p3);
    endtask

    initial begin
        // Reset-state vectors: lane bases 0, 48, 96, 144 on rows 8..11.
        vt[0]  = '{0,   256, 4'hF, 1'b1, 0};
        vt[1]  = '{31,  270, 4'hF, 1'b1, 0};
        vt[2]  = '{32,  287, 4'hF, 1'b0, 0};
        vt[3]  = '{128, 260, 4'hF, 1'b1, 0};
        vt[4]  = '{639, 256, 4'hF, 1'b0, 0};
        vt[5]  = '{47,  300, 4'hF, 1'b0, 0};
        vt[6]  = '{48,  300, 4'hF, 1'b1, 1};
        vt[7]  = '{79,  319, 4'hF, 1'b1, 1};
        vt[8]  = '{80,  300, 4'hF, 1'b0, 0};
        vt[9]  = '{127, 320, 4'hF, 1'b1, 2};
        vt[10] = '{128, 320, 4'hF, 1'b0, 0};
        vt[11] = '{95,  351, 4'hF, 1'b0, 0};
        vt[12] = '{224, 340, 4'hF, 1'b1, 2};
        vt[13] = '{144, 352, 4'hF, 1'b1, 3};
        vt[14] = '{16,  383, 4'hF, 1'b1, 3};
        vt[15] = '{0,   255, 4'hF, 1'b0, 0};
        vt[16] = '{0,   384, 4'hF, 1'b0, 0};
        vt[17] = '{768, 256, 4'hF, 1'b0, 0};
        vt[18] = '{0,   256, 4'hE, 1'b0, 0};

        rst_n       = 1'b0;
        frame_start = 1'b0;
        restart     = 1'b0;
        lane_en     = 4'hF;
        dir         = 4'h0;
        speed_div   = '0;
        h           = '0;
        v           = '0;
        frog_x      = 10'd600;
        frog_y      = 10'd0;
        mflag       = 1'b0;
        model_restart();

        // 1: reset
        repeat (2) @(posedge clk);
        #1;
        check("rst_pix", 32'(car_pixel), 0);
        check("rst_lid", 32'(lane_id), 0);
        check("rst_col", 32'(collision), 0);
        check_pos_hand("rst", 0, 48, 96, 144);
        $display("reset released cyc=%0d", cyc);
        rst_n = 1'b1;

        // 4: pixel map table
        for (int i = 0; i < 19; i++) begin
            lane_en = vt[i].en;
            drive_cycle(1'b0, 1'b0, vt[i].h, vt[i].v, 1'b1, vt[i].pix, vt[i].lid);
            $display("vec %0d h=%0d v=%0d en=%h want pix=%0d lane=%0d", i, vt[i].h, vt[i].v,
                     vt[i].en, vt[i].pix, vt[i].lid);
        end
        lane_en = 4'hF;

        // 2: speed and direction
        lane_en   = 4'b0011;
        dir       = 4'b0010;
        speed_div = 24'h000080;
        for (int i = 0; i < 6; i++) begin
            pulse();
            check_pos_model($sformatf("spd%0d", i));
        end
        check_pos_hand("spd_final", 12, 44, 96, 144);

        // 3: wrap both ways, split car at screen edge
        do_restart();
        lane_en   = 4'b0001;
        dir       = 4'b0001;
        speed_div = '0;
        pulse();
        check_pos_hand("wrap_left", 638, 48, 96, 144);
        dir = 4'b0000;
        pulse();
        check_pos_hand("wrap_right", 0, 48, 96, 144);
        dir = 4'b0001;
        repeat (5) pulse();
        check_pos_hand("wrap_630", 630, 48, 96, 144);
        drive_cycle(1'b0, 1'b0, 0,   256, 1'b1, 1'b1, 0);
        drive_cycle(1'b0, 1'b0, 639, 256, 1'b1, 1'b1, 0);
        drive_cycle(1'b0, 1'b0, 21,  256, 1'b1, 1'b1, 0);
        drive_cycle(1'b0, 1'b0, 22,  256, 1'b1, 1'b0, 0);
        drive_cycle(1'b0, 1'b0, 629, 256, 1'b1, 1'b0, 0);
        $display("split-car queries issued cyc=%0d", cyc);

        // 5: collision
        do_restart();
        lane_en   = 4'b0001;
        dir       = 4'b0000;
        speed_div = 24'hFFFFFF;
        frog_x    = 10'd0;
        frog_y    = 10'd256;
        pulse();
        scan_box(0, 256, 32, 4);
        pulse();
        check("col_hit", 32'(collision), 1);
        idle();
        check("col_once", 32'(collision), 0);

        frog_x = 10'd300;
        frog_y = 10'd100;
        scan_box(0, 256, 32, 4);
        pulse();
        check("col_clear", 32'(collision), 0);

        frog_x = 10'd32;
        frog_y = 10'd256;
        scan_box(0, 256, 64, 2);
        pulse();
        check("col_edge_out", 32'(collision), 0);

        frog_x = 10'd31;
        scan_box(0, 256, 64, 2);
        pulse();
        check("col_edge_in", 32'(collision), 1);

        lane_en = 4'b0000;
        frog_x  = 10'd0;
        scan_box(0, 256, 32, 4);
        pulse();
        check("col_disabled", 32'(collision), 0);

        // 6: restart beats frame start
        do_restart();
        lane_en   = 4'b0001;
        speed_div = 24'hFFFFC0;
        pulse();
        check_pos_hand("prio_pre", 2, 48, 96, 144);
        scan_box(0, 256, 32, 4);
        drive_cycle(1'b1, 1'b1, 0, 0, 1'b0, 1'b0, 0);
        $display("restart+frame cyc=%0d", cyc);
        check("prio_col", 32'(collision), 0);
        check_pos_hand("prio", 0, 48, 96, 144);
        pulse();
        check("prio_flag", 32'(collision), 0);
        check_pos_hand("prio_post", 2, 48, 96, 144);

        // Let the last scoreboard entries retire, bounded.
        repeat (3) @(negedge clk);
        #1;
        check("sb_drain", sbq.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
